if_icache_stage: RTL and testbench

- Instruction-fetch stage with a direct-mapped instruction cache. It sits directly upstream of the memory controller's IF port.
- Holds the PC and looks up each fetch in the cache.
- On a miss, it issues a 4-byte read to the memory controller and fills the cache line from the returned word.
- On a hit, it delivers {pc, inst} to the IF/ID register. The redirect input comes from EX and the stall input comes from the stall controller.

---
 rtl/if_icache_stage.sv | 115 +++++++++++
 tb/tb_if_icache_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/if_icache_stage.sv
// Instruction-fetch stage backed by a direct-mapped, one-word-per-line instruction cache.
// Misses issue a single-word read to the memory controller and stall until it returns.
module if_icache_stage #(
  parameter int unsigned      INDEX_W  = 6,
  parameter int unsigned      ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              stall_in,
  input  logic              jump_in,
  input  logic [ADDR_W-1:0] jumpAddr_in,
  input  logic              memInstE_in,
  input  logic [31:0]       memInst_in,
  output logic              memReq_out,
  output logic [ADDR_W-1:0] memAddr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       inst_out,
  output logic              instValid_out
);

  localparam int unsigned Lines = 1 << INDEX_W;
  localparam int unsigned TagW  = ADDR_W - INDEX_W - 2;

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StMiss = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic [31:0]       inst_out_q, inst_out_d;
  logic              valid_out_q, valid_out_d;

  logic [Lines-1:0]  line_valid_q;
  logic [TagW-1:0]   tag_q  [Lines];
  logic [31:0]       data_q [Lines];

  logic [INDEX_W-1:0] idx, fill_idx;
  logic [TagW-1:0]    tag, fill_tag;
  logic               hit, fill_we;

  assign idx      = pc_q[INDEX_W+1:2];
  assign tag      = pc_q[ADDR_W-1:INDEX_W+2];
  assign hit      = line_valid_q[idx] && (tag_q[idx] == tag);
  assign fill_idx = mem_addr_q[INDEX_W+1:2];
  assign fill_tag = mem_addr_q[ADDR_W-1:INDEX_W+2];
  assign fill_we  = (state_q == StMiss) && memInstE_in;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    pc_out_d    = pc_out_q;
    inst_out_d  = inst_out_q;
    valid_out_d = valid_out_q;
    if (state_q == StMiss) begin
      // A redirect never cancels the outstanding fill; it only retargets the PC.
      if (memInstE_in) state_d = StRun;
      if (jump_in) begin
        pc_d        = jumpAddr_in;
        valid_out_d = 1'b0;
      end
    end else if (jump_in) begin
      pc_d        = jumpAddr_in;
      valid_out_d = 1'b0;
    end else if (!stall_in) begin
      if (hit) begin
        pc_out_d    = pc_q;
        inst_out_d  = data_q[idx];
        valid_out_d = 1'b1;
        pc_d        = pc_q + ADDR_W'(4);
      end else begin
        state_d     = StMiss;
        mem_addr_d  = {pc_q[ADDR_W-1:2], 2'b00};
        valid_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      mem_addr_q   <= '0;
      pc_out_q     <= '0;
      inst_out_q   <= '0;
      valid_out_q  <= 1'b0;
      line_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      pc_out_q    <= pc_out_d;
      inst_out_q  <= inst_out_d;
      valid_out_q <= valid_out_d;
      if (fill_we) line_valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage needs no reset: the valid bits gate every use.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= memInst_in;
    end
  end

  assign memReq_out    = (state_q == StMiss) && !memInstE_in;
  assign memAddr_out   = mem_addr_q;
  assign pc_out        = pc_out_q;
  assign inst_out      = inst_out_q;
  assign instValid_out = valid_out_q;

endmodule

// File: tb/tb_if_icache_stage.sv
// Bench for if_icache_stage: directed scenarios plus randomized traffic, all checked
// against a cycle-level reference model of the fetch stage and its cache.
module tb_if_icache_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        stall_in, jump_in, memInstE_in;
  logic [31:0] jumpAddr_in, memInst_in;
  logic        memReq_out, instValid_out;
  logic [31:0] memAddr_out, pc_out, inst_out;

  int n_checks = 0;
  int n_errors = 0;

  if_icache_stage dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .stall_in      (stall_in),
    .jump_in       (jump_in),
    .jumpAddr_in   (jumpAddr_in),
    .memInstE_in   (memInstE_in),
    .memInst_in    (memInst_in),
    .memReq_out    (memReq_out),
    .memAddr_out   (memAddr_out),
    .pc_out        (pc_out),
    .inst_out      (inst_out),
    .instValid_out (instValid_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model state
  logic [31:0] m_pc, m_maddr, m_pc_out, m_inst_out;
  logic        m_miss, m_vout;
  bit          c_valid [64];
  logic [23:0] c_tag   [64];
  logic [31:0] c_data  [64];
  int          wait_left, max_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00100093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_maddr = 32'h0; m_pc_out = 32'h0; m_inst_out = 32'h0;
    m_miss = 1'b0; m_vout = 1'b0;
    for (int i = 0; i < 64; i++) c_valid[i] = 1'b0;
  endtask

  // One clock: drive at negedge, check, advance the model at the rising edge.
  task automatic step(input logic st, input logic jp, input logic [31:0] ja, input logic me);
    logic [31:0] data;
    int          li;
    data = me ? (m_miss ? mem_word(m_maddr) : $urandom) : $urandom;
    stall_in = st; jump_in = jp; jumpAddr_in = ja; memInstE_in = me; memInst_in = data;
    #1;
    check("memReq", {31'b0, memReq_out}, {31'b0, m_miss && !me});
    check("memAddr", memAddr_out, m_maddr);
    check("pc_out", pc_out, m_pc_out);
    check("inst_out", inst_out, m_inst_out);
    check("instValid", {31'b0, instValid_out}, {31'b0, m_vout});
    @(posedge clk_in);
    if (m_miss) begin
      if (me) begin
        li = (m_maddr / 4) % 64;
        c_valid[li] = 1'b1;
        c_tag[li]   = m_maddr[31:8];
        c_data[li]  = data;
        m_miss      = 1'b0;
      end
      if (jp) begin m_pc = ja; m_vout = 1'b0; end
    end else if (jp) begin
      m_pc = ja; m_vout = 1'b0;
    end else if (!st) begin
      li = (m_pc / 4) % 64;
      if (c_valid[li] && c_tag[li] == m_pc[31:8]) begin
        m_pc_out = m_pc; m_inst_out = c_data[li]; m_vout = 1'b1;
        m_pc = m_pc + 32'd4;
      end else begin
        m_miss = 1'b1; m_maddr = m_pc & ~32'h3; m_vout = 1'b0;
      end
    end
    @(negedge clk_in);
  endtask

  // Memory responder: completes each outstanding miss after a bounded random wait.
  task automatic auto_step(input logic st, input logic jp, input logic [31:0] ja);
    logic me = 1'b0;
    if (m_miss) begin
      if (wait_left <= 0) begin me = 1'b1; wait_left = $urandom_range(0, max_wait); end
      else wait_left--;
    end else begin
      me = ($urandom_range(0, 19) == 0);
    end
    step(st, jp, ja, me);
  endtask

  task automatic settle();
    if (m_miss) step(1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    logic [31:0] ja;
    rst_in = 1'b1; stall_in = 0; jump_in = 0; jumpAddr_in = 0; memInstE_in = 0; memInst_in = 0;
    model_reset();
    repeat (2) @(negedge clk_in);
    check("rst_memReq", {31'b0, memReq_out}, 32'h0);
    check("rst_valid", {31'b0, instValid_out}, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_memAddr", memAddr_out, 32'h0);
    rst_in = 1'b0;

    // Cold start
    step(0, 0, 0, 0);
    check("cold_req", {31'b0, memReq_out}, 32'h1);
    check("cold_addr", memAddr_out, 32'h0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("cold_valid", {31'b0, instValid_out}, 32'h1);
    check("cold_pc", pc_out, 32'h0);
    check("cold_inst", inst_out, 32'h00100093);

    // Preload a few lines, then replay them as a hit stream
    max_wait = 1; wait_left = 1;
    repeat (20) auto_step(0, 0, 0);
    settle();
    step(0, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check("hit_pc", pc_out, 32'(i * 4));
      check("hit_valid", {31'b0, instValid_out}, 32'h1);
      check("hit_req", {31'b0, memReq_out}, 32'h0);
    end

    // Conflict eviction on index 0
    settle();
    step(0, 1, 32'h100, 0);
    step(0, 0, 0, 0);
    check("conf_req", {31'b0, memReq_out}, 32'h1);
    check("conf_addr", memAddr_out, 32'h100);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h0, 0);
    step(0, 0, 0, 0);
    check("evict_req", {31'b0, memReq_out}, 32'h1);
    check("evict_addr", memAddr_out, 32'h0);
    step(0, 0, 0, 1);

    // Jump while a miss is outstanding
    step(0, 1, 32'h40, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 32'h80, 0);
    check("jm_addr", memAddr_out, 32'h40);
    check("jm_valid", {31'b0, instValid_out}, 32'h0);
    step(0, 0, 0, 0);
    check("jm_addr_hold", memAddr_out, 32'h40);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("jm_new_req", {31'b0, memReq_out}, 32'h1);
    check("jm_new_addr", memAddr_out, 32'h80);
    step(0, 0, 0, 1);
    step(0, 1, 32'h40, 0);
    step(0, 0, 0, 0);
    check("jm_hit_valid", {31'b0, instValid_out}, 32'h1);
    check("jm_hit_pc", pc_out, 32'h40);
    check("jm_hit_inst", inst_out, mem_word(32'h40));

    // Stall holds outputs; jump under stall clears valid
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0);
      check("stall_pc", pc_out, 32'h40);
      check("stall_valid", {31'b0, instValid_out}, 32'h1);
    end
    step(1, 1, 32'h20, 0);
    check("sj_valid", {31'b0, instValid_out}, 32'h0);
    step(0, 0, 0, 0);
    check("sj_req", {31'b0, memReq_out}, 32'h1);
    check("sj_addr", memAddr_out, 32'h20);

    // Asynchronous reset in the middle of a miss
    #2 rst_in = 1'b1;
    #1;
    check("arst_req", {31'b0, memReq_out}, 32'h0);
    check("arst_valid", {31'b0, instValid_out}, 32'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    step(0, 0, 0, 0);
    check("arst_refill_req", {31'b0, memReq_out}, 32'h1);
    check("arst_refill_addr", memAddr_out, 32'h0);

    // Randomized traffic
    max_wait = 5; wait_left = 2;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) ja = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else ja = 32'($urandom_range(0, 511) * 4);
      auto_step($urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0, ja);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
